alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the CPU's combinational ALU. It registers all single-cycle operations and adds iterative unsigned multiply (low/high word) and unsigned divide/remainder. Operands are accepted and results returned through a valid/ready handshake. It sits in the execute stage and stalls the core through `in_ready` while an iterative operation is in flight.

---
 rtl/alu_mc.sv | 192 +++++++++++++++++++
 tb/tb_alu_mc.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the execute stage.
//   Single-cycle logic/arithmetic/compare/shift ops are registered and valid
//   one cycle after acceptance. MUL/MULH (radix-2 shift-add) and DIVU/REMU
//   (restoring division, MSB first) take WIDTH iterations, valid WIDTH+1
//   cycles after acceptance. in_ready stalls the core while busy.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake; alu_op, data_i_1 (A), data_i_2 (B)
//   flush                synchronous abort; drops any pending/in-flight op
//   out_valid/out_ready  result handshake; data_o result
//   zero, sign, neg      flags from registered data_o (==0, !=0, MSB)
module alu_mc #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] data_i_1,
  input  logic [WIDTH-1:0] data_i_2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_o,
  output logic             zero,
  output logic             sign,
  output logic             neg
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_NE   = 4'b1001;
  localparam logic [3:0] OP_ZN   = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_MULH = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     data_q,  data_d;
  logic [3:0]           op_q,    op_d;
  // Multiplicand (A) for MUL/MULH, divisor (B) for DIVU/REMU.
  logic [WIDTH-1:0]     opnd_q,  opnd_d;
  // MUL: {partial product high, remaining multiplier bits}.
  // DIV: {partial remainder, dividend bits shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0]   acc_q,   acc_d;
  logic [SHW-1:0]       cnt_q,   cnt_d;

  logic                 accept;
  logic                 new_is_iter;
  logic                 new_is_div;
  logic                 cur_is_div;
  logic                 last_step;
  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     iter_res;

  assign in_ready    = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept      = in_valid & in_ready;
  assign new_is_div  = (alu_op == OP_DIVU) | (alu_op == OP_REMU);
  assign new_is_iter = new_is_div | (alu_op == OP_MUL) | (alu_op == OP_MULH);
  assign cur_is_div  = (op_q == OP_DIVU) | (op_q == OP_REMU);
  assign last_step   = (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_AND:  alu_res = data_i_1 & data_i_2;
      OP_OR:   alu_res = data_i_1 | data_i_2;
      OP_XOR:  alu_res = data_i_1 ^ data_i_2;
      OP_NOR:  alu_res = ~(data_i_1 | data_i_2);
      OP_ADD:  alu_res = data_i_1 + data_i_2;
      OP_SUB:  alu_res = data_i_1 - data_i_2;
      OP_SLT:  alu_res = WIDTH'(data_i_1 < data_i_2);
      OP_SLL:  alu_res = data_i_2 << data_i_1[SHW-1:0];
      OP_EQ:   alu_res = WIDTH'(data_i_1 == data_i_2);
      OP_NE:   alu_res = WIDTH'(data_i_1 != data_i_2);
      OP_ZN:   alu_res = WIDTH'((data_i_1 == '0) | data_i_1[WIDTH-1]);
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: bring the next dividend bit into the remainder, keep the
  // difference only if it did not go negative. A zero divisor never restores,
  // which yields an all-ones quotient and remainder == A without special-casing.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    iter_res = '0;
    case (op_q)
      OP_MUL:  iter_res = mul_next[WIDTH-1:0];
      OP_MULH: iter_res = mul_next[2*WIDTH-1:WIDTH];
      OP_DIVU: iter_res = div_next[WIDTH-1:0];
      OP_REMU: iter_res = div_next[2*WIDTH-1:WIDTH];
      default: iter_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_ITER: begin
          acc_d = cur_is_div ? div_next : mul_next;
          cnt_d = cnt_q + SHW'(1);
          if (last_step) begin
            state_d = S_DONE;
            data_d  = iter_res;
            cnt_d   = '0;
          end
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: ;
      endcase
      // Acceptance in DONE overrides the return to IDLE so the next op
      // starts on the same edge the old result transfers.
      if (accept) begin
        op_d  = alu_op;
        cnt_d = '0;
        if (new_is_iter) begin
          state_d = S_ITER;
          if (new_is_div) begin
            opnd_d = data_i_2;
            acc_d  = {{WIDTH{1'b0}}, data_i_1};
          end else begin
            opnd_d = data_i_1;
            acc_d  = {{WIDTH{1'b0}}, data_i_2};
          end
        end else begin
          state_d = S_DONE;
          data_d  = alu_res;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign data_o    = data_q;
  assign zero      = (data_q == '0);
  assign sign      = |data_q;
  assign neg       = data_q[WIDTH-1];

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  localparam int unsigned W = 32;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_NOR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_EQ   = 4'h8;
  localparam logic [3:0] OP_NE   = 4'h9;
  localparam logic [3:0] OP_ZN   = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_MULH = 4'hC;
  localparam logic [3:0] OP_DIVU = 4'hD;
  localparam logic [3:0] OP_REMU = 4'hE;
  localparam logic [3:0] OP_UND  = 4'hF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] data_o;
  logic         zero, sign, neg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .data_i_1  (a),
    .data_i_2  (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o),
    .zero      (zero),
    .sign      (sign),
    .neg       (neg)
  );

  // Reference: plain arithmetic on wide integers.
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_SLT:  r = (x < y) ? 1 : 0;
      OP_SLL:  r = y << (x % W);
      OP_EQ:   r = (x == y) ? 1 : 0;
      OP_NE:   r = (x != y) ? 1 : 0;
      OP_ZN:   r = (x == 0 || x >= 32'h8000_0000) ? 1 : 0;
      OP_MUL:  r = p[W-1:0];
      OP_MULH: r = p[2*W-1:W];
      OP_DIVU: r = (y == 0) ? {W{1'b1}} : x / y;
      OP_REMU: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic bit is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: at most one result owed by the unit.
  bit           have_res = 0;
  int           res_cycle = 0;
  logic [W-1:0] res_val = '0;
  logic [W-1:0] last_out = '0;
  bit           res_has_lit = 0;
  logic [W-1:0] res_lit = '0;
  bit           lit_pending = 0;
  logic [W-1:0] lit_val = '0;
  bit           exp_valid, exp_ready;

  // Single compare process; everything is sampled mid-cycle, and the model
  // is advanced as if the following rising edge had happened.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      have_res = 0;
      res_has_lit = 0;
      last_out = '0;
      check("rst_out_valid", out_valid, 0);
      check("rst_data", data_o, 0);
      check("rst_zero", zero, 1);
      check("rst_sign", sign, 0);
      check("rst_neg", neg, 0);
    end else begin
      exp_valid = have_res && (cyc >= res_cycle);
      exp_ready = !flush && (!have_res || (exp_valid && out_ready));
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, exp_ready);
      if (exp_valid) begin
        check("data_o", data_o, res_val);
        check("zero", zero, res_val == 0);
        check("sign", sign, res_val != 0);
        check("neg", neg, res_val[W-1]);
        if (res_has_lit) begin
          check("literal", data_o, res_lit);
          res_has_lit = 0;
        end
        last_out = res_val;
      end else if (!have_res) begin
        check("idle_data", data_o, last_out);
        check("idle_zero", zero, last_out == 0);
        check("idle_sign", sign, last_out != 0);
        check("idle_neg", neg, last_out[W-1]);
      end
      if (flush) begin
        have_res = 0;
        res_has_lit = 0;
      end else begin
        if (exp_valid && out_ready) have_res = 0;
        if (in_valid && exp_ready) begin
          have_res    = 1;
          res_val     = model(alu_op, a, b);
          res_cycle   = cyc + (is_iter(alu_op) ? W + 1 : 1);
          res_has_lit = lit_pending;
          res_lit     = lit_val;
        end
      end
    end
  end

  // Phase: all stimulus changes happen 2 time units after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit haslit, input logic [W-1:0] lit);
    bit got;
    got = 0;
    in_valid = 1; alu_op = op; a = x; b = y;
    lit_pending = haslit; lit_val = lit;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #2;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept_timeout: op %h not accepted within 200 cycles", op);
    end
    in_valid = 0;
    lit_pending = 0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (have_res && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (have_res) begin
      checks++; failures++;
      $display("FAIL done_timeout: result not delivered within 200 cycles");
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] e;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{OP_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00});
    vecs.push_back('{OP_OR,   32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F});
    vecs.push_back('{OP_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F});
    vecs.push_back('{OP_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF});
    vecs.push_back('{OP_SUB,  32'h0,         32'h1,         32'hFFFF_FFFF});
    vecs.push_back('{OP_SUB,  32'd10,        32'd3,         32'd7});
    vecs.push_back('{OP_SLT,  32'd5,         32'd5,         32'd0});
    vecs.push_back('{OP_SLL,  32'd33,        32'd3,         32'd6});
    vecs.push_back('{OP_EQ,   32'd5,         32'd5,         32'd1});
    vecs.push_back('{OP_NE,   32'd5,         32'd5,         32'd0});
    vecs.push_back('{OP_ZN,   32'h0,         32'h9,         32'd1});
    vecs.push_back('{OP_ZN,   32'h8000_0000, 32'h0,         32'd1});
    vecs.push_back('{OP_ZN,   32'h1,         32'h0,         32'd0});
    vecs.push_back('{OP_UND,  32'hFFFF,      32'hFFFF,      32'd0});
    vecs.push_back('{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
    vecs.push_back('{OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0});
    vecs.push_back('{OP_MULH, 32'h0001_0000, 32'h0001_0000, 32'h1});
    vecs.push_back('{OP_DIVU, 32'd100,       32'd7,         32'd14});
    vecs.push_back('{OP_REMU, 32'd100,       32'd7,         32'd2});
    vecs.push_back('{OP_DIVU, 32'h1234,      32'h0,         32'hFFFF_FFFF});
    vecs.push_back('{OP_REMU, 32'h1234,      32'h0,         32'h1234});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF});
    vecs.push_back('{OP_REMU, 32'd7,         32'd9,         32'd7});

    cycles(3);
    rst_n = 1;
    cycles(1);

    // Leave a nonzero result, then reset in the middle of a multiply.
    drive(OP_OR, 32'h5, 32'hA, 1, 32'hF);
    wait_done();
    drive(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0);
    cycles(5);
    rst_n = 0;
    cycles(2);
    rst_n = 1;
    cycles(2);

    // Back-to-back single-cycle ops.
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1, 32'h0);
    drive(OP_SLL, 32'h4, 32'h1, 1, 32'h10);
    drive(OP_SLT, 32'h3, 32'h8000_0000, 1, 32'h1);
    wait_done();

    // Directed table; iterative ops are followed immediately by the next
    // request so acceptance in DONE is exercised.
    foreach (vecs[i]) drive(vecs[i].op, vecs[i].x, vecs[i].y, 1, vecs[i].e);
    wait_done();

    // Backpressure after a divide, released together with a new AND.
    out_ready = 0;
    drive(OP_DIVU, 32'd1000, 32'd10, 1, 32'd100);
    cycles(W);
    cycles(5);
    out_ready = 1;
    drive(OP_AND, 32'hF0, 32'h3C, 1, 32'h30);
    wait_done();

    // Flush at iteration 10 of a multiply; XOR two cycles later.
    drive(OP_MUL, 32'h1234, 32'h5678, 0, '0);
    cycles(9);
    flush = 1;
    cycles(1);
    flush = 0;
    cycles(1);
    drive(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 1, 32'h5555_5555);
    wait_done();
    cycles(40);

    // Flush while a result is held, with a competing request in the same cycle.
    out_ready = 0;
    drive(OP_ADD, 32'd1, 32'd2, 1, 32'd3);
    cycles(2);
    flush = 1;
    in_valid = 1; alu_op = OP_SUB; a = 32'd9; b = 32'd4;
    cycles(1);
    flush = 0;
    in_valid = 0;
    cycles(2);
    out_ready = 1;
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
